// File: rtl/pattern_sequencer.sv
// Frame-level pattern time-sharing controller: selects one generator, ramps the
// shared step size on frame boundaries, and inserts black frames between patterns.
module pattern_sequencer #(
  parameter int          NUM_PATTERNS = 4,
  parameter int          DWELL_FRAMES = 600,
  parameter int          BLANK_FRAMES = 8,
  parameter logic [11:0] RAMP_INC     = 12'h004
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      next_frame,
  input  logic                      active,
  input  logic                      advance_req,
  input  logic                      hold,
  input  logic [1:0]                speed_sel,
  input  logic [6*NUM_PATTERNS-1:0] pattern_rgb,
  output logic [NUM_PATTERNS-1:0]   pattern_enable,
  output logic [11:0]               step_size,
  output logic [2:0]                pattern_index,
  output logic                      blanking,
  output logic [5:0]                rgb
);
  localparam int DW = $clog2(DWELL_FRAMES);
  localparam int BW = $clog2(BLANK_FRAMES + 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] blank_cnt;
  logic          pending;
  logic [11:0]   target;
  logic [12:0]   ramp_sum;
  logic [11:0]   step_nxt;
  logic [2:0]    index_nxt;
  logic          leave_show;
  logic [NUM_PATTERNS-1:0][5:0] slices;
  logic [5:0]    rgb_sel;

  always_comb begin
    target = 12'h010;
    case (speed_sel)
      2'b00: target = 12'h010;
      2'b01: target = 12'h020;
      2'b10: target = 12'h040;
      2'b11: target = 12'h008;
      default: target = 12'h010;
    endcase
  end

  // 13-bit sum so a large RAMP_INC saturates at the target instead of wrapping
  always_comb begin
    ramp_sum = {1'b0, step_size} + {1'b0, RAMP_INC};
    step_nxt = target;
    if (step_size < target)
      step_nxt = (ramp_sum > {1'b0, target}) ? target : ramp_sum[11:0];
  end

  assign index_nxt  = (pattern_index == 3'(NUM_PATTERNS - 1)) ? 3'd0 : pattern_index + 3'd1;
  assign leave_show = pending || advance_req ||
                      (!hold && dwell_cnt == DW'(DWELL_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SHOW;
      pattern_index  <= 3'd0;
      pattern_enable <= NUM_PATTERNS'(1);
      step_size      <= 12'd0;
      blanking       <= 1'b0;
      dwell_cnt      <= '0;
      blank_cnt      <= '0;
      pending        <= 1'b0;
    end else begin
      case (state)
        SHOW: begin
          if (next_frame) begin
            step_size <= step_nxt;
            if (leave_show) begin
              state          <= BLANK;
              blanking       <= 1'b1;
              pattern_enable <= '0;
              dwell_cnt      <= '0;
              blank_cnt      <= '0;
              pending        <= 1'b0;
            end else if (!hold) begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end else if (advance_req) begin
            pending <= 1'b1;
          end
        end
        BLANK: begin
          if (next_frame) begin
            if (blank_cnt == BW'(BLANK_FRAMES - 1)) begin
              state          <= SHOW;
              blanking       <= 1'b0;
              pattern_index  <= index_nxt;
              pattern_enable <= NUM_PATTERNS'(1) << index_nxt;
              step_size      <= 12'd0;
              blank_cnt      <= '0;
            end else begin
              blank_cnt <= blank_cnt + BW'(1);
            end
          end
        end
        default: state <= SHOW;
      endcase
    end
  end

  assign slices = pattern_rgb;

  always_comb begin
    rgb_sel = 6'd0;
    for (int i = 0; i < NUM_PATTERNS; i++)
      if (pattern_index == 3'(i)) rgb_sel = slices[i];
  end

  assign rgb = (active && !blanking) ? rgb_sel : 6'd0;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench: directed frame sequences plus random traffic against a
// frame-level behavioural model of the sequencer.
module tb_pattern_sequencer;
  localparam int NUM = 3, DWELL = 4, BLNK = 2, INC = 4;

  logic            clk = 0;
  logic            rst, next_frame, active, advance_req, hold;
  logic [1:0]      speed_sel;
  logic [6*NUM-1:0] pattern_rgb;
  logic [NUM-1:0]  pattern_enable;
  logic [11:0]     step_size;
  logic [2:0]      pattern_index;
  logic            blanking;
  logic [5:0]      rgb;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  pattern_sequencer #(.NUM_PATTERNS(NUM), .DWELL_FRAMES(DWELL), .BLANK_FRAMES(BLNK),
                      .RAMP_INC(12'(INC))) dut (
    .clk(clk), .rst(rst), .next_frame(next_frame), .active(active),
    .advance_req(advance_req), .hold(hold), .speed_sel(speed_sel),
    .pattern_rgb(pattern_rgb), .pattern_enable(pattern_enable), .step_size(step_size),
    .pattern_index(pattern_index), .blanking(blanking), .rgb(rgb));

  always #5 clk = ~clk;

  // Behavioural model: pattern number, frames shown so far, black frames so far
  bit m_show, m_pend;
  int m_idx, m_step, m_shown, m_black;

  function automatic int tgt(input logic [1:0] s);
    case (s)
      2'b00: return 16;
      2'b01: return 32;
      2'b10: return 64;
      default: return 8;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_show = 1; m_pend = 0; m_idx = 0; m_step = 0; m_shown = 0; m_black = 0;
    end else if (m_show) begin
      if (advance_req) m_pend = 1;
      if (next_frame) begin
        int t;
        t = tgt(speed_sel);
        m_step = (m_step + INC < t) ? m_step + INC : t;
        if (m_pend || (!hold && m_shown + 1 == DWELL)) begin
          m_show = 0; m_pend = 0; m_shown = 0; m_black = 0;
        end else if (!hold) m_shown++;
      end
    end else if (next_frame) begin
      m_black++;
      if (m_black == BLNK) begin
        m_show = 1; m_idx = (m_idx + 1) % NUM; m_step = 0; m_black = 0;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("model_index", pattern_index, m_idx);
    check("model_enable", pattern_enable, m_show ? (1 << m_idx) : 0);
    check("model_step", step_size, m_step);
    check("model_blanking", blanking, !m_show);
    check("model_rgb", rgb, (active && m_show) ? ((pattern_rgb >> (6 * m_idx)) & 6'h3f) : 0);
  end

  task automatic cyc(input bit r, input bit nf, input bit adv);
    rst = r; next_frame = nf; advance_req = adv;
    @(posedge clk); #2;
    rst = 0; next_frame = 0; advance_req = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin cyc(0, 1, 0); cyc(0, 0, 0); end
    #1;
  endtask

  initial begin
    rst = 1; next_frame = 0; active = 1; advance_req = 0; hold = 0; speed_sel = 2'b00;
    pattern_rgb = {6'h33, 6'h22, 6'h11};
    cyc(1, 0, 0); cyc(1, 0, 0); #1;
    chk_en = 1;
    check("rst_index", pattern_index, 0);
    check("rst_enable", pattern_enable, 3'b001);
    check("rst_step", step_size, 0);
    check("rst_blanking", blanking, 0);
    check("rst_rgb", rgb, 6'h11);

    frames(4);
    check("auto_blank", blanking, 1);
    check("auto_enable0", pattern_enable, 0);
    check("auto_step16", step_size, 16);
    check("blank_rgb", rgb, 0);
    frames(2);
    check("auto_index1", pattern_index, 1);
    check("auto_step0", step_size, 0);
    check("mux_slice1", rgb, 6'h22);
    active = 0; #1;
    check("mux_inactive", rgb, 0);
    active = 1;

    hold = 1;
    frames(5);
    check("ramp_16", step_size, 16);
    speed_sel = 2'b11;
    frames(1);
    check("ramp_down_8", step_size, 8);
    frames(20);
    check("hold_index", pattern_index, 1);
    check("hold_blanking", blanking, 0);

    cyc(0, 1, 1); #1;
    check("manual_same_cycle", blanking, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(1, 1, 1); #1;
    check("rst_mid_index", pattern_index, 0);
    check("rst_mid_blanking", blanking, 0);
    check("rst_mid_step", step_size, 0);
    check("rst_mid_enable", pattern_enable, 3'b001);

    cyc(0, 0, 1);
    frames(1);
    check("pend_blank", blanking, 1);
    cyc(0, 0, 1);
    frames(2);
    check("one_incr_index", pattern_index, 1);
    frames(4);
    check("one_incr_hold", pattern_index, 1);
    check("one_incr_show", blanking, 0);
    frames(2);
    check("mux_slice2_wait", pattern_index, 1);

    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) hold = $urandom_range(1);
      if ($urandom_range(99) == 0) speed_sel = 2'($urandom);
      if ($urandom_range(3) == 0) pattern_rgb = 18'($urandom);
      active = $urandom_range(1);
      cyc($urandom_range(499) == 0, $urandom_range(3) == 0, $urandom_range(15) == 0);
    end
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
